// File: rtl/oam_dma_controller.sv
// OAM DMA controller.
// A write to 0xFF46 starts a copy of XFER_LEN bytes from {hi,8'h00} into OAM.
// While idle the CPU owns the memory port (pure pass-through). While active
// the DMA engine owns it, and the CPU is limited to high RAM (0xFF80-0xFFFE).
//
// Handshake: there is no valid/ready pair here. dma_start_i is a one-cycle
// pulse that is always accepted (and restarts a running transfer), and
// dma_done_o is a one-cycle pulse that needs no acknowledge. mem_rdata_i is
// valid the cycle after an address is presented with mem_oe_o high.
//
// Each byte takes four cycles: read setup, read latch, write setup, write
// commit. State and byte index are exported on dbg_state_o / dbg_idx_o.
module oam_dma_controller #(
    parameter int          XFER_LEN = 160,
    parameter logic [15:0] OAM_BASE = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_start_i,
    input  logic [7:0]  dma_src_hi_i,
    input  logic [15:0] cpu_address_i,
    input  logic        cpu_oe_i,
    input  logic        cpu_we_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [15:0] mem_address_o,
    output logic        mem_oe_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_wdata_o,
    output logic        cpu_blocked_o,
    output logic        oam_lock_o,
    output logic        dma_active_o,
    output logic        dma_done_o,
    output logic [2:0]  dbg_state_o,
    output logic [7:0]  dbg_idx_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_SETUP  = 3'd1,
        S_RD_LATCH  = 3'd2,
        S_WR_SETUP  = 3'd3,
        S_WR_COMMIT = 3'd4
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] src_q, src_d;
    logic [7:0]  byte_q, byte_d;
    logic        done_q, done_d;

    logic [15:0] start_src;
    logic        hram_access;
    logic        engine_busy;

    // Source base for a new transfer; pages 0xE0-0xFF are echo RAM and fold
    // down onto 0xC0-0xDF by clearing address bit 13.
    always_comb begin
        start_src = {dma_src_hi_i, 8'h00};
        if (dma_src_hi_i >= 8'hE0) begin
            start_src[13] = 1'b0;
        end
    end

    // State, byte index, source base, data holding register and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 8'h00;
            src_q   <= 16'h0000;
            byte_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            src_q   <= src_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; a start pulse restarts from byte 0 in any state,
    // including the final commit (that cycle's write still goes out).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        src_d   = src_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        if (dma_start_i) begin
            state_d = S_RD_SETUP;
            idx_d   = 8'h00;
            src_d   = start_src;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_RD_SETUP: begin
                    state_d = S_RD_LATCH;
                end
                S_RD_LATCH: begin
                    state_d = S_WR_SETUP;
                    byte_d  = mem_rdata_i;
                end
                S_WR_SETUP: begin
                    state_d = S_WR_COMMIT;
                end
                S_WR_COMMIT: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RD_SETUP;
                        idx_d   = idx_q + 8'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Memory port mux: CPU pass-through when idle, DMA source/OAM otherwise.
    always_comb begin
        mem_address_o = cpu_address_i;
        mem_oe_o      = cpu_oe_i;
        mem_we_o      = cpu_we_i;
        mem_wdata_o   = 8'h00;
        engine_busy   = 1'b0;
        case (state_q)
            S_RD_SETUP, S_RD_LATCH: begin
                mem_address_o = src_q + {8'h00, idx_q};
                mem_oe_o      = 1'b1;
                mem_we_o      = 1'b0;
                engine_busy   = 1'b1;
            end
            S_WR_SETUP: begin
                mem_address_o = OAM_BASE + {8'h00, idx_q};
                mem_oe_o      = 1'b0;
                mem_we_o      = 1'b0;
                mem_wdata_o   = byte_q;
                engine_busy   = 1'b1;
            end
            S_WR_COMMIT: begin
                mem_address_o = OAM_BASE + {8'h00, idx_q};
                mem_oe_o      = 1'b0;
                mem_we_o      = 1'b1;
                mem_wdata_o   = byte_q;
                engine_busy   = 1'b1;
            end
            default: begin
                engine_busy = 1'b0;
            end
        endcase
    end

    // CPU restriction: only high RAM is exempt from blocking while active.
    always_comb begin
        hram_access   = (cpu_address_i >= 16'hFF80) && (cpu_address_i <= 16'hFFFE);
        cpu_blocked_o = engine_busy && (cpu_oe_i || cpu_we_i) && !hram_access;
    end

    assign dma_active_o = engine_busy;
    assign oam_lock_o   = engine_busy;
    assign dma_done_o   = done_q;
    assign dbg_state_o  = state_q;
    assign dbg_idx_o    = idx_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: a flat 64 KiB memory unit, a cycle-count
// reference model of the transfer, table vectors for CPU pass-through and
// restriction, and hand sequences for restart, reset and echo source.
module tb_oam_dma_controller;

    localparam int XFER = 160;
    localparam int LAT  = 4 * XFER;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        dma_start = 1'b0;
    logic [7:0]  dma_src_hi = 8'h00;
    logic [15:0] cpu_address = 16'h0000;
    logic        cpu_oe = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] mem_address;
    logic        mem_oe, mem_we;
    logic [7:0]  mem_wdata;
    logic        cpu_blocked, oam_lock, dma_active, dma_done;
    logic [2:0]  dbg_state;
    logic [7:0]  dbg_idx;

    oam_dma_controller #(.XFER_LEN(XFER), .OAM_BASE(16'hFE00)) dut (
        .clk          (clk),
        .rst          (rst),
        .dma_start_i  (dma_start),
        .dma_src_hi_i (dma_src_hi),
        .cpu_address_i(cpu_address),
        .cpu_oe_i     (cpu_oe),
        .cpu_we_i     (cpu_we),
        .mem_rdata_i  (mem_rdata),
        .mem_address_o(mem_address),
        .mem_oe_o     (mem_oe),
        .mem_we_o     (mem_we),
        .mem_wdata_o  (mem_wdata),
        .cpu_blocked_o(cpu_blocked),
        .oam_lock_o   (oam_lock),
        .dma_active_o (dma_active),
        .dma_done_o   (dma_done),
        .dbg_state_o  (dbg_state),
        .dbg_idx_o    (dbg_idx)
    );

    // ---------------- memory unit ----------------
    logic [7:0] mem [0:65535];
    logic [7:0] bus_wdata;
    assign bus_wdata = dma_active ? mem_wdata : cpu_wdata;

    always @(posedge clk) begin
        if (mem_we) mem[mem_address] <= bus_wdata;
        mem_rdata <= mem[mem_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Echo RAM 0xE000-0xFFFF mirrors 0xC000 downwards by 0x2000.
    function automatic logic [15:0] src_of(input logic [7:0] hi);
        logic [15:0] s;
        s = {hi, 8'h00};
        if (hi >= 8'hE0) s = s - 16'h2000;
        return s;
    endfunction

    // m_k counts cycles since the accepted start (1..LAT); byte = (k-1)/4,
    // phase = (k-1)%4 gives read,read,write-setup,write-commit.
    bit          m_active = 1'b0;
    bit          m_done = 1'b0;
    int          m_k = 0;
    logic [15:0] m_src = 16'h0000;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_k      = 0;
        end else begin
            m_done = 1'b0;
            if (dma_start) begin
                m_active = 1'b1;
                m_k      = 1;
                m_src    = src_of(dma_src_hi);
            end else if (m_active) begin
                if (m_k == LAT) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_k = m_k + 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] pat [2][XFER];
    int checks = 0;
    int errors = 0;
    int active_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    bit rand_cpu = 1'b0;

    typedef struct {
        bit          act;
        logic [15:0] addr;
        bit          oe;
        bit          we;
        logic [15:0] exp_addr;
        bit          exp_oe;
        bit          exp_we;
        bit          exp_blk;
    } vec_t;
    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle_check();
        int i, ph;
        logic hram, eblk;
        logic [15:0] ea;
        if (rst) return;
        hram = (cpu_address >= 16'hFF80) && (cpu_address <= 16'hFFFE);
        eblk = m_active && (cpu_oe || cpu_we) && !hram;
        check("dma_active", dma_active, m_active);
        check("oam_lock", oam_lock, m_active);
        check("dma_done", dma_done, m_done);
        check("cpu_blocked", cpu_blocked, eblk);
        if (m_active) begin
            i  = (m_k - 1) / 4;
            ph = (m_k - 1) % 4;
            ea = (ph < 2) ? m_src + 16'(i) : 16'hFE00 + 16'(i);
            check("dma_addr", mem_address, ea);
            check("dma_oe", mem_oe, ph < 2);
            check("dma_we", mem_we, ph == 3);
            if (ph >= 2 && i < exp_q.size()) check("dma_wdata", mem_wdata, exp_q[i]);
        end else begin
            check("pass_addr", mem_address, cpu_address);
            check("pass_oe", mem_oe, cpu_oe);
            check("pass_we", mem_we, cpu_we);
        end
        if (dma_active) active_cnt++;
        if (dma_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_cpu) begin
                cpu_address = ($urandom_range(0, 3) == 0) ? 16'hFF80 + 16'($urandom_range(0, 127))
                                                          : 16'($urandom);
                cpu_oe    = 1'($urandom_range(0, 1));
                cpu_we    = dma_active ? 1'($urandom_range(0, 1)) : 1'b0;
                cpu_wdata = 8'($urandom);
            end
            #2;
            cycle_check();
        end
    endtask

    task automatic pulse_start(input logic [7:0] hi);
        dma_src_hi = hi;
        dma_start  = 1'b1;
        tick(1);
        dma_start  = 1'b0;
        start_cyc  = cyc;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_address = a;
        cpu_oe      = 1'b0;
        cpu_we      = 1'b1;
        cpu_wdata   = d;
        tick(1);
        cpu_we      = 1'b0;
    endtask

    task automatic load_src(input int bank, input logic [15:0] base, input bit use_5a);
        logic [7:0] d;
        for (int i = 0; i < XFER; i++) begin
            d = use_5a ? (8'(i) ^ 8'h5A) : 8'($urandom_range(0, 255));
            pat[bank][i] = d;
            cpu_write(base + 16'(i), d);
        end
    endtask

    task automatic set_exp(input int bank);
        exp_q.delete();
        for (int i = 0; i < XFER; i++) exp_q.push_back(pat[bank][i]);
    endtask

    task automatic clr_counts();
        active_cnt = 0;
        done_cnt   = 0;
        done_cyc   = 0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done_cnt == 0 && n < limit) begin
            tick(1);
            n++;
        end
        check("done_seen", done_cnt != 0, 1);
    endtask

    task automatic end_checks();
        check("latency", done_cyc - start_cyc, LAT);
        for (int i = 0; i < XFER; i++) check("oam_byte", mem[16'hFE00 + 16'(i)], exp_q[i]);
    endtask

    task automatic idle_cpu();
        rand_cpu = 1'b0;
        cpu_oe   = 1'b0;
        cpu_we   = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        logic [7:0] hi;
        vecs[0]  = '{0, 16'hC123, 0, 1, 16'hC123, 0, 1, 0};
        vecs[1]  = '{0, 16'h8000, 1, 0, 16'h8000, 1, 0, 0};
        vecs[2]  = '{0, 16'hFF85, 1, 0, 16'hFF85, 1, 0, 0};
        vecs[3]  = '{0, 16'h4567, 0, 0, 16'h4567, 0, 0, 0};
        vecs[4]  = '{0, 16'hFF90, 0, 1, 16'hFF90, 0, 1, 0};
        vecs[5]  = '{1, 16'hC000, 1, 0, 16'h0000, 0, 0, 1};
        vecs[6]  = '{1, 16'hFF85, 0, 1, 16'h0000, 0, 0, 0};
        vecs[7]  = '{1, 16'hFF80, 1, 0, 16'h0000, 0, 0, 0};
        vecs[8]  = '{1, 16'hFFFE, 0, 1, 16'h0000, 0, 0, 0};
        vecs[9]  = '{1, 16'hFFFF, 1, 0, 16'h0000, 0, 0, 1};
        vecs[10] = '{1, 16'hFF7F, 0, 1, 16'h0000, 0, 0, 1};
        vecs[11] = '{1, 16'hFE00, 1, 1, 16'h0000, 0, 0, 1};
        vecs[12] = '{1, 16'hC000, 0, 0, 16'h0000, 0, 0, 0};

        // Reset values, with CPU inputs visible through the idle mux.
        cpu_address = 16'h1234;
        cpu_oe      = 1'b1;
        #3;
        check("rst_active", dma_active, 0);
        check("rst_lock", oam_lock, 0);
        check("rst_blocked", cpu_blocked, 0);
        check("rst_done", dma_done, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_addr", mem_address, 16'h1234);
        check("rst_oe", mem_oe, 1);
        check("rst_idx", dbg_idx, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cpu_oe = 1'b0;
        tick(2);

        // Idle pass-through vectors.
        for (int v = 0; v < 13; v++) begin
            if (!vecs[v].act) begin
                cpu_address = vecs[v].addr;
                cpu_oe      = vecs[v].oe;
                cpu_we      = vecs[v].we;
                cpu_wdata   = 8'h00;
                #1;
                check("idle_addr", mem_address, vecs[v].exp_addr);
                check("idle_oe", mem_oe, vecs[v].exp_oe);
                check("idle_we", mem_we, vecs[v].exp_we);
                check("idle_blocked", cpu_blocked, vecs[v].exp_blk);
                check("idle_active", dma_active, 0);
                tick(1);
                cpu_we = 1'b0;
                cpu_oe = 1'b0;
            end
        end

        // Full transfer from 0xC000 with i^0x5A, CPU restriction vectors inside.
        load_src(0, 16'hC000, 1'b1);
        set_exp(0);
        clr_counts();
        pulse_start(8'hC0);
        tick(8);
        for (int v = 0; v < 13; v++) begin
            if (vecs[v].act) begin
                cpu_address = vecs[v].addr;
                cpu_oe      = vecs[v].oe;
                cpu_we      = vecs[v].we;
                cpu_wdata   = 8'h77;
                #1;
                check("act_blocked", cpu_blocked, vecs[v].exp_blk);
                tick(1);
            end
        end
        rand_cpu = 1'b1;
        wait_done(LAT + 50);
        idle_cpu();
        end_checks();
        check("active_cycles", active_cnt, LAT);
        tick(3);
        check("done_once", done_cnt, 1);

        // Echo source page 0xE1 reads from 0xC100.
        load_src(0, 16'hC100, 1'b0);
        set_exp(0);
        clr_counts();
        pulse_start(8'hE1);
        check("echo_first_addr", mem_address, 16'hC100);
        check("echo_first_oe", mem_oe, 1);
        rand_cpu = 1'b1;
        wait_done(LAT + 50);
        idle_cpu();
        end_checks();

        // Random source pages with random data and random CPU traffic.
        for (int t = 0; t < 3; t++) begin
            hi = 8'($urandom_range(0, 255));
            load_src(0, src_of(hi), 1'b0);
            set_exp(0);
            clr_counts();
            pulse_start(hi);
            rand_cpu = 1'b1;
            wait_done(LAT + 50);
            idle_cpu();
            end_checks();
            check("rand_active_cycles", active_cnt, LAT);
            tick(2);
            check("rand_done_once", done_cnt, 1);
        end

        // Restart at byte 50 with a new source page 0xD0.
        load_src(0, 16'hC200, 1'b0);
        load_src(1, 16'hD000, 1'b0);
        set_exp(0);
        clr_counts();
        pulse_start(8'hC2);
        rand_cpu = 1'b1;
        tick(200);
        rand_cpu = 1'b0;
        pulse_start(8'hD0);
        check("restart_idx", dbg_idx, 0);
        check("restart_addr", mem_address, 16'hD000);
        set_exp(1);
        rand_cpu = 1'b1;
        wait_done(LAT + 50);
        idle_cpu();
        end_checks();
        tick(3);
        check("restart_done_once", done_cnt, 1);

        // Restart landing on the final write commit: that write still happens.
        load_src(0, 16'hC400, 1'b0);
        load_src(1, 16'hC500, 1'b0);
        set_exp(0);
        clr_counts();
        pulse_start(8'hC4);
        rand_cpu = 1'b1;
        tick(LAT - 1);
        rand_cpu = 1'b0;
        check("last_commit_we", mem_we, 1);
        check("last_commit_addr", mem_address, 16'hFE9F);
        check("last_commit_wdata", mem_wdata, pat[0][XFER-1]);
        pulse_start(8'hC5);
        check("last_byte_written", mem[16'hFE9F], pat[0][XFER-1]);
        check("no_done_on_restart", dma_done, 0);
        check("restart2_addr", mem_address, 16'hC500);
        set_exp(1);
        rand_cpu = 1'b1;
        wait_done(LAT + 50);
        idle_cpu();
        end_checks();
        tick(3);
        check("restart2_done_once", done_cnt, 1);

        // Reset at byte 80: OAM keeps bytes 0..79, the rest stays 0xEE.
        for (int i = 0; i < XFER; i++) cpu_write(16'hFE00 + 16'(i), 8'hEE);
        load_src(0, 16'hC300, 1'b0);
        set_exp(0);
        clr_counts();
        pulse_start(8'hC3);
        rand_cpu = 1'b1;
        tick(4 * 80);
        rand_cpu    = 1'b0;
        cpu_address = 16'hABCD;
        cpu_oe      = 1'b1;
        cpu_we      = 1'b0;
        dma_start   = 1'b1;
        dma_src_hi  = 8'hC0;
        #1 rst = 1'b1;
        #1;
        check("mid_rst_active", dma_active, 0);
        check("mid_rst_lock", oam_lock, 0);
        check("mid_rst_blocked", cpu_blocked, 0);
        check("mid_rst_done", dma_done, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_addr", mem_address, 16'hABCD);
        check("mid_rst_oe", mem_oe, 1);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_idx", dbg_idx, 0);
        @(posedge clk);
        #1;
        check("start_vs_rst", dma_active, 0);
        dma_start = 1'b0;
        cpu_oe    = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        tick(6);
        check("rst_no_done", done_cnt, 0);
        for (int i = 0; i < XFER; i++) begin
            if (i < 80) check("rst_oam_kept", mem[16'hFE00 + 16'(i)], exp_q[i]);
            else        check("rst_oam_untouched", mem[16'hFE00 + 16'(i)], 8'hEE);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
